// File: rtl/usb_fs_nb_out_pe.sv
// usb_fs_nb_out_pe: full-speed OUT/SETUP protocol engine.
// Accepts OUT/SETUP tokens for this device and streams DATA0/DATA1 payload
// bytes into the selected endpoint buffer. It tracks the data toggle for each
// endpoint and answers with an ACK, NAK or STALL handshake. Handshake, acked
// and rollback strobes are registered, so they appear one cycle after the
// decision is made.
module usb_fs_nb_out_pe #(
  parameter int NumOutEps         = 11,
  parameter int MaxOutPktSizeByte = 32,
  parameter int PktW              = $clog2(MaxOutPktSizeByte),
  parameter int OutEpW            = $clog2(NumOutEps)
) (
  input  logic                 clk_48mhz_i,
  input  logic                 rst_ni,
  input  logic                 link_reset_i,
  input  logic [6:0]           dev_addr_i,

  output logic [3:0]           out_ep_current_o,
  output logic                 out_ep_data_put_o,
  output logic [PktW-1:0]      out_ep_put_addr_o,
  output logic [7:0]           out_ep_data_o,
  output logic                 out_ep_newpkt_o,
  output logic                 out_ep_acked_o,
  output logic                 out_ep_rollback_o,
  output logic                 out_ep_setup_o,
  input  logic [NumOutEps-1:0] out_ep_full_i,
  input  logic [NumOutEps-1:0] out_ep_stall_i,

  input  logic                 rx_pkt_start_i,
  input  logic                 rx_pkt_end_i,
  input  logic                 rx_pkt_valid_i,
  input  logic [3:0]           rx_pid_i,
  input  logic [6:0]           rx_addr_i,
  input  logic [3:0]           rx_endp_i,
  input  logic                 rx_data_put_i,
  input  logic [7:0]           rx_data_i,

  output logic                 tx_pkt_start_o,
  output logic [3:0]           tx_pid_o
);

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;
  localparam logic [PktW:0] MaxCnt = (PktW+1)'(MaxOutPktSizeByte);

  typedef enum logic [1:0] {
    StIdle,
    StRcvdOut,
    StRcvdData,
    StRcvdDataEnd
  } state_e;

  state_e state_q, state_d;

  logic [NumOutEps-1:0] toggle_q;
  // One bit wider than the buffer address so the byte past the end is visible
  logic [PktW:0]        byte_cnt_q;
  logic                 overflow_q;
  logic                 rx_put_q;

  logic [OutEpW-1:0]    ep;
  logic                 tok, tok_accept, ep_full, ep_stall;
  logic                 newpkt_d, rollback_d, acked_d, tx_start_d, tog_flip;
  logic [3:0]           tx_pid_d;

  assign ep       = out_ep_current_o[OutEpW-1:0];
  assign ep_full  = out_ep_full_i[ep];
  // SETUP must always get through to a halted endpoint
  assign ep_stall = out_ep_stall_i[ep] & ~out_ep_setup_o;

  assign tok = rx_pkt_end_i & rx_pkt_valid_i & (rx_pid_i[1:0] == 2'b01)
             & (rx_addr_i == dev_addr_i)
             & ({1'b0, rx_endp_i} < 5'(NumOutEps));
  assign tok_accept = tok & ((rx_pid_i == PidOut) | (rx_pid_i == PidSetup))
                    & (state_q != StRcvdDataEnd);

  // The buffer is written only while there is room and the endpoint is not blocked
  assign out_ep_data_put_o = rx_put_q & (byte_cnt_q < MaxCnt) & ~ep_full & ~ep_stall;
  assign out_ep_put_addr_o = byte_cnt_q[PktW-1:0];

  // Next state and the handshake / commit decision
  always_comb begin
    state_d    = state_q;
    newpkt_d   = 1'b0;
    rollback_d = 1'b0;
    acked_d    = 1'b0;
    tx_start_d = 1'b0;
    tx_pid_d   = 4'b0000;
    tog_flip   = 1'b0;
    if (tok_accept) begin
      state_d  = StRcvdOut;
      newpkt_d = 1'b1;
      // A new token arriving mid-payload discards the unfinished packet
      rollback_d = (state_q == StRcvdData);
    end else begin
      unique case (state_q)
        StRcvdOut: begin
          if (rx_pkt_start_i) state_d = StRcvdData;
        end
        StRcvdData: begin
          if (rx_pkt_end_i) begin
            if (rx_pkt_valid_i && rx_pid_i[1:0] == 2'b11) begin
              state_d = StRcvdDataEnd;
            end else begin
              state_d    = StIdle;
              rollback_d = 1'b1;
            end
          end
        end
        StRcvdDataEnd: begin
          state_d = StIdle;
          if (overflow_q) begin
            rollback_d = 1'b1;
          end else if (ep_stall) begin
            tx_start_d = 1'b1;
            tx_pid_d   = PidStall;
            rollback_d = 1'b1;
          end else if (ep_full) begin
            tx_start_d = 1'b1;
            tx_pid_d   = PidNak;
            rollback_d = 1'b1;
          end else if (rx_pid_i[3] == toggle_q[ep]) begin
            tx_start_d = 1'b1;
            tx_pid_d   = PidAck;
            acked_d    = 1'b1;
            tog_flip   = 1'b1;
          end else begin
            // Duplicate of a packet we already committed: ACK it again, keep nothing
            tx_start_d = 1'b1;
            tx_pid_d   = PidAck;
            rollback_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State register and registered strobes
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= StIdle;
      out_ep_newpkt_o   <= 1'b0;
      out_ep_rollback_o <= 1'b0;
      out_ep_acked_o    <= 1'b0;
      tx_pkt_start_o    <= 1'b0;
      tx_pid_o          <= 4'b0000;
    end else if (link_reset_i) begin
      state_q           <= StIdle;
      out_ep_newpkt_o   <= 1'b0;
      out_ep_rollback_o <= 1'b0;
      out_ep_acked_o    <= 1'b0;
      tx_pkt_start_o    <= 1'b0;
      tx_pid_o          <= 4'b0000;
    end else begin
      state_q           <= state_d;
      out_ep_newpkt_o   <= newpkt_d;
      out_ep_rollback_o <= rollback_d;
      out_ep_acked_o    <= acked_d;
      tx_pkt_start_o    <= tx_start_d;
      tx_pid_o          <= tx_pid_d;
    end
  end

  // Transfer context, byte counter, overflow flag and data toggles
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_ep_current_o <= 4'h0;
      out_ep_setup_o   <= 1'b0;
      out_ep_data_o    <= 8'h00;
      byte_cnt_q       <= '0;
      overflow_q       <= 1'b0;
      rx_put_q         <= 1'b0;
      toggle_q         <= '0;
    end else if (link_reset_i) begin
      out_ep_current_o <= 4'h0;
      out_ep_setup_o   <= 1'b0;
      out_ep_data_o    <= 8'h00;
      byte_cnt_q       <= '0;
      overflow_q       <= 1'b0;
      rx_put_q         <= 1'b0;
      toggle_q         <= '0;
    end else begin
      rx_put_q <= rx_data_put_i & (state_q == StRcvdData);
      if (rx_data_put_i && state_q == StRcvdData) out_ep_data_o <= rx_data_i;

      if (tok_accept) begin
        out_ep_current_o <= rx_endp_i;
        out_ep_setup_o   <= (rx_pid_i == PidSetup);
        byte_cnt_q       <= '0;
        overflow_q       <= 1'b0;
        if (rx_pid_i == PidSetup) toggle_q[rx_endp_i[OutEpW-1:0]] <= 1'b0;
      end else if (rx_put_q) begin
        // Counting continues while puts are suppressed so overflow is still seen
        if (byte_cnt_q == MaxCnt) overflow_q <= 1'b1;
        else                      byte_cnt_q <= byte_cnt_q + 1'b1;
      end

      if (tog_flip) toggle_q[ep] <= ~toggle_q[ep];
    end
  end

endmodule

// File: tb/tb_usb_fs_nb_out_pe.sv
// Directed bench for usb_fs_nb_out_pe: token/data sequences with hand-derived outcomes.
module tb_usb_fs_nb_out_pe;

  localparam int NumOutEps = 11;
  localparam int PktW      = 5;

  localparam logic [3:0] OUT   = 4'b0001;
  localparam logic [3:0] SETUP = 4'b1101;
  localparam logic [3:0] IN    = 4'b1001;
  localparam logic [3:0] DATA0 = 4'b0011;
  localparam logic [3:0] DATA1 = 4'b1011;
  localparam logic [6:0] DEV   = 7'h05;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 link_reset_i = 1'b0;
  logic [3:0]           out_ep_current_o;
  logic                 out_ep_data_put_o;
  logic [PktW-1:0]      out_ep_put_addr_o;
  logic [7:0]           out_ep_data_o;
  logic                 out_ep_newpkt_o, out_ep_acked_o, out_ep_rollback_o, out_ep_setup_o;
  logic [NumOutEps-1:0] out_ep_full_i = '0;
  logic [NumOutEps-1:0] out_ep_stall_i = '0;
  logic                 rx_pkt_start_i = 1'b0, rx_pkt_end_i = 1'b0, rx_pkt_valid_i = 1'b0;
  logic [3:0]           rx_pid_i = 4'h0;
  logic [6:0]           rx_addr_i = 7'h0;
  logic [3:0]           rx_endp_i = 4'h0;
  logic                 rx_data_put_i = 1'b0;
  logic [7:0]           rx_data_i = 8'h0;
  logic                 tx_pkt_start_o;
  logic [3:0]           tx_pid_o;

  usb_fs_nb_out_pe dut (
    .clk_48mhz_i       (clk),
    .rst_ni            (rst_ni),
    .link_reset_i      (link_reset_i),
    .dev_addr_i        (DEV),
    .out_ep_current_o  (out_ep_current_o),
    .out_ep_data_put_o (out_ep_data_put_o),
    .out_ep_put_addr_o (out_ep_put_addr_o),
    .out_ep_data_o     (out_ep_data_o),
    .out_ep_newpkt_o   (out_ep_newpkt_o),
    .out_ep_acked_o    (out_ep_acked_o),
    .out_ep_rollback_o (out_ep_rollback_o),
    .out_ep_setup_o    (out_ep_setup_o),
    .out_ep_full_i     (out_ep_full_i),
    .out_ep_stall_i    (out_ep_stall_i),
    .rx_pkt_start_i    (rx_pkt_start_i),
    .rx_pkt_end_i      (rx_pkt_end_i),
    .rx_pkt_valid_i    (rx_pkt_valid_i),
    .rx_pid_i          (rx_pid_i),
    .rx_addr_i         (rx_addr_i),
    .rx_endp_i         (rx_endp_i),
    .rx_data_put_i     (rx_data_put_i),
    .rx_data_i         (rx_data_i),
    .tx_pkt_start_o    (tx_pkt_start_o),
    .tx_pid_o          (tx_pid_o)
  );

  always #10 clk = ~clk;

  // Output monitor, sampled on the falling edge
  int              cnt_newpkt = 0, cnt_acked = 0, cnt_rb = 0, cnt_tx = 0, cnt_both = 0;
  logic [3:0]      last_pid = 4'h0;
  logic [PktW-1:0] put_addr_q[$];
  logic [7:0]      put_data_q[$];

  always @(negedge clk) begin
    if (rst_ni) begin
      if (out_ep_data_put_o) begin
        put_addr_q.push_back(out_ep_put_addr_o);
        put_data_q.push_back(out_ep_data_o);
      end
      if (out_ep_newpkt_o)   cnt_newpkt <= cnt_newpkt + 1;
      if (out_ep_acked_o)    cnt_acked  <= cnt_acked + 1;
      if (out_ep_rollback_o) cnt_rb     <= cnt_rb + 1;
      if (out_ep_acked_o && out_ep_rollback_o) cnt_both <= cnt_both + 1;
      if (tx_pkt_start_o) begin
        cnt_tx   <= cnt_tx + 1;
        last_pid <= tx_pid_o;
      end
    end
  end

  int n_checks = 0;
  int n_errs   = 0;
  int s_np, s_ack, s_rb, s_tx, s_put;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_np  = cnt_newpkt;
    s_ack = cnt_acked;
    s_rb  = cnt_rb;
    s_tx  = cnt_tx;
    s_put = put_addr_q.size();
  endtask

  task automatic expect_txn(input string tag, input int np, input int puts, input int tx,
                            input int pid, input int ack, input int rb);
    check({tag, " newpkt"},   cnt_newpkt - s_np,        np);
    check({tag, " puts"},     put_addr_q.size() - s_put, puts);
    check({tag, " tx"},       cnt_tx - s_tx,            tx);
    if (tx > 0) check({tag, " pid"}, 32'(last_pid), pid);
    check({tag, " acked"},    cnt_acked - s_ack,        ack);
    check({tag, " rollback"}, cnt_rb - s_rb,            rb);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
    step(1);
    rx_pkt_start_i = 1'b1;
    step(1);
    rx_pkt_start_i = 1'b0;
    step(2);
    rx_pid_i = pid; rx_addr_i = addr; rx_endp_i = endp;
    rx_pkt_valid_i = 1'b1; rx_pkt_end_i = 1'b1;
    step(1);
    rx_pkt_end_i = 1'b0; rx_pkt_valid_i = 1'b0;
    step(2);
  endtask

  // rst_at >= 0 pulses link reset just before that byte index
  task automatic send_data(input logic [3:0] pid, input int n, input logic [7:0] first,
                           input logic valid, input int rst_at);
    step(1);
    rx_pkt_start_i = 1'b1;
    step(1);
    rx_pkt_start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        link_reset_i = 1'b1;
        step(1);
        link_reset_i = 1'b0;
      end
      rx_data_i = first + 8'(i);
      rx_data_put_i = 1'b1;
      step(1);
      rx_data_put_i = 1'b0;
      step(1);
    end
    step(2);
    rx_pid_i = pid; rx_pkt_valid_i = valid; rx_pkt_end_i = 1'b1;
    step(1);
    rx_pkt_end_i = 1'b0; rx_pkt_valid_i = 1'b0;
    step(6);
  endtask

  task automatic out_txn(input logic [3:0] tpid, input logic [3:0] ep, input logic [3:0] dpid,
                         input int n, input logic [7:0] first);
    snap();
    send_token(tpid, DEV, ep);
    send_data(dpid, n, first, 1'b1, -1);
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst put",     32'(out_ep_data_put_o), 0);
    check("rst newpkt",  32'(out_ep_newpkt_o), 0);
    check("rst tx",      32'(tx_pkt_start_o), 0);
    check("rst current", 32'(out_ep_current_o), 0);
    check("rst setup",   32'(out_ep_setup_o), 0);
    check("rst addr",    32'(out_ep_put_addr_o), 0);
    rst_ni = 1'b1;
    step(2);

    // 1: SETUP ep0, DATA0, bytes 0..7
    out_txn(SETUP, 4'd0, DATA0, 8, 8'h00);
    expect_txn("t1", 1, 8, 1, 'h2, 1, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1 addr%0d", i), 32'(put_addr_q[s_put + i]), i);
      check($sformatf("t1 data%0d", i), 32'(put_data_q[s_put + i]), i);
    end
    check("t1 setup",   32'(out_ep_setup_o), 1);
    check("t1 current", 32'(out_ep_current_o), 0);
    // toggle0 is now 1: DATA1 commits
    out_txn(OUT, 4'd0, DATA1, 2, 8'h40);
    expect_txn("t1 d1", 1, 2, 1, 'h2, 1, 0);
    check("t1 setup clr", 32'(out_ep_setup_o), 0);

    // 2: OUT ep1 DATA0, then repeated DATA0, then DATA1
    out_txn(OUT, 4'd1, DATA0, 4, 8'h10);
    expect_txn("t2 first", 1, 4, 1, 'h2, 1, 0);
    check("t2 current", 32'(out_ep_current_o), 1);
    out_txn(OUT, 4'd1, DATA0, 4, 8'h10);
    expect_txn("t2 dup", 1, 4, 1, 'h2, 0, 1);
    out_txn(OUT, 4'd1, DATA1, 4, 8'h20);
    expect_txn("t2 next", 1, 4, 1, 'h2, 1, 0);

    // 3: full then stall on ep2
    out_ep_full_i[2] = 1'b1;
    out_txn(OUT, 4'd2, DATA0, 3, 8'h30);
    expect_txn("t3 nak", 1, 0, 1, 'hA, 0, 1);
    out_ep_full_i[2] = 1'b0;
    out_ep_stall_i[2] = 1'b1;
    out_txn(OUT, 4'd2, DATA0, 3, 8'h30);
    expect_txn("t3 stall", 1, 0, 1, 'hE, 0, 1);
    out_ep_stall_i[2] = 1'b0;
    out_txn(OUT, 4'd2, DATA0, 3, 8'h30);
    expect_txn("t3 ok", 1, 3, 1, 'h2, 1, 0);

    // 4: 33-byte packet on ep3 overflows
    out_txn(OUT, 4'd3, DATA0, 33, 8'h80);
    expect_txn("t4 ovf", 1, 32, 0, 0, 0, 1);
    check("t4 first addr", 32'(put_addr_q[s_put]), 0);
    check("t4 last addr",  32'(put_addr_q[s_put + 31]), 31);
    check("t4 last data",  32'(put_data_q[s_put + 31]), 'h9F);
    out_txn(OUT, 4'd3, DATA0, 2, 8'h50);
    expect_txn("t4 after", 1, 2, 1, 'h2, 1, 0);
    check("t4 addr0", 32'(put_addr_q[s_put]), 0);
    check("t4 addr1", 32'(put_addr_q[s_put + 1]), 1);

    // 5: ignored tokens, bad CRC data
    snap();
    send_token(OUT, 7'h06, 4'd4);
    send_data(DATA0, 2, 8'h00, 1'b1, -1);
    expect_txn("t5 addr", 0, 0, 0, 0, 0, 0);
    snap();
    send_token(OUT, DEV, 4'd12);
    send_data(DATA0, 2, 8'h00, 1'b1, -1);
    expect_txn("t5 endp", 0, 0, 0, 0, 0, 0);
    snap();
    send_token(IN, DEV, 4'd4);
    expect_txn("t5 in", 0, 0, 0, 0, 0, 0);
    snap();
    send_token(OUT, DEV, 4'd4);
    send_data(DATA0, 2, 8'h00, 1'b0, -1);
    expect_txn("t5 crc", 1, 2, 0, 0, 0, 1);

    // 6: link reset mid-data clears toggles
    out_txn(OUT, 4'd5, DATA0, 2, 8'h60);
    expect_txn("t6 prep", 1, 2, 1, 'h2, 1, 0);
    snap();
    send_token(SETUP, DEV, 4'd5);
    send_data(DATA1, 3, 8'h70, 1'b1, 1);
    expect_txn("t6 lrst", 1, 1, 0, 0, 0, 0);
    check("t6 current", 32'(out_ep_current_o), 0);
    check("t6 setup",   32'(out_ep_setup_o), 0);
    out_txn(OUT, 4'd5, DATA0, 2, 8'h61);
    expect_txn("t6 ep5", 1, 2, 1, 'h2, 1, 0);
    out_txn(SETUP, 4'd0, DATA0, 1, 8'h01);
    expect_txn("t6 setup0", 1, 1, 1, 'h2, 1, 0);

    check("acked/rollback exclusive", cnt_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
